step_driver_if: RTL
===================

Name: step_driver_if

Overview:
- Downstream stage of the acceleration/step-timing controller.
- Consumes its `step` pulses plus a direction bit and produces electrically valid STEP/DIR/ENABLE signals for an external stepper driver chip.
- Enforces minimum STEP high/low widths and DIR setup time, and buffers steps that arrive faster than the driver timing allows.
- Maintains a signed absolute position counter for the printer's status readback.

Parameters:
- PULSE_HIGH, 5, drv_step high time in clk cycles (>=1)
- PULSE_LOW, 5, drv_step minimum low time in clk cycles (>=1)
- DIR_SETUP, 10, cycles drv_dir must be stable before a drv_step rising edge (>=1)
- POS_WIDTH, 32, width of position counter
- PEND_WIDTH, 4, width of pending-step counter (max pending = 2^PEND_WIDTH-1)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- enable_in  input  1  axis enable
- dir_in  input  1  requested direction (1 = positive)
- step_in  input  1  step request from acceleration controller; rising edge = one step
- clear  input  1  one-cycle pulse: zero position, clear overrun
- drv_step  output  1  STEP to driver
- drv_dir  output  1  DIR to driver
- drv_enable_n  output  1  driver enable, active-low
- position  output  POS_WIDTH  signed absolute position
- busy  output  1  high when pending != 0 or FSM != IDLE
- overrun  output  1  sticky: a step was dropped
- endstop_hit  output  1  sticky endstop flag (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: drv_step=0, drv_dir=0, drv_enable_n=1, position=0, busy=0, overrun=0, endstop_hit=0, pending=0, FSM=IDLE, step_in history=0.
- drv_enable_n is registered as ~enable_in, so it has 1-cycle latency.
- Edge detect: an edge is counted at a posedge where step_in=1 and the registered previous step_in=0. It is counted only while enable_in=1.
- pending counter:
  - +1 per counted edge.
  - -1 on FSM entry to HIGH.
  - Both in the same cycle: pending is unchanged.
  - Edge while pending is at max with no simultaneous decrement: the step is dropped and overrun is set (sticky).
- FSM states: IDLE, SETUP, HIGH, LOW.
  - IDLE, pending>0, enable_in=1, dir_in==drv_dir: go to HIGH.
  - IDLE, pending>0, enable_in=1, dir_in!=drv_dir: drv_dir<=dir_in, go to SETUP.
  - SETUP: hold for DIR_SETUP cycles, then go to HIGH.
  - HIGH: drv_step=1 for PULSE_HIGH cycles, then go to LOW.
  - LOW: drv_step=0 for PULSE_LOW cycles, then go to IDLE.
- Position: on entry to HIGH, position += 1 if drv_dir=1, else -1. Two's-complement wrap-around; no saturation.
- Latency: edge counted at cycle N gives drv_step=1 at cycle N+2 when no direction change is needed (IDLE sees pending at N+1). With a direction change, the rise is at N+2+DIR_SETUP.
- Back-to-back steps: minimum step period is PULSE_HIGH+PULSE_LOW+1 cycles, since IDLE lasts 1 cycle.
- dir_in is sampled only in IDLE. Changes during SETUP/HIGH/LOW apply to the next step.
- enable_in falling:
  - pending is cleared the same cycle.
  - An in-progress HIGH/LOW completes normally, then the FSM returns to IDLE.
  - SETUP aborts to IDLE immediately.
  - No pulse is truncated.
- clear: position<=0 and overrun<=0 next cycle. It has priority over a simultaneous position update (that step's ±1 is lost). clear does not affect pending or the FSM.
- busy is combinational from registered state.

Optional Feature:
- Macro: STEP_ENDSTOP_EN.
- Defined:
  - Adds input port endstop_min (1, active-high, pre-synchronised).
  - In IDLE with pending>0, if the resolved direction is 0 and endstop_min=1: pending is cleared, no pulse is issued, position<=0, endstop_hit<=1.
  - endstop_hit is cleared by reset or clear.
  - Positive-direction steps are unaffected.
- Undefined: port endstop_min is absent and endstop_hit is constant 0.

Test Plan:
- Single step with defaults, dir_in=0 = drv_dir: edge at cycle 10 -> drv_step high cycles 12-16, low from 17, position=-1, busy falls at cycle 22.
- Direction change: dir_in=1, one edge at cycle 10 -> drv_dir=1 at cycle 12, drv_step rises at cycle 22, position=+1.
- Burst: 20 edges every 2 cycles, PEND_WIDTH=4 -> overrun=1. Exactly the number accepted before saturation is emitted. Pulse spacing is exactly 11 cycles. Final position equals emitted count.
- Disable mid-pulse: enable_in=0 during HIGH with pending=3 -> the current pulse completes its 5 high cycles, no further pulses, pending=0, drv_enable_n=1 one cycle after.
- Wrap and clear: POS_WIDTH=4, position=7, one positive step -> position=-8. Then clear -> position=0, overrun=0.
- STEP_ENDSTOP_EN: endstop_min=1, dir_in=0, 3 edges -> no drv_step, position=0, endstop_hit=1. Then dir_in=1, 1 edge -> pulse issued, position=1.

Source files
------------

// File: rtl/step_driver_if.sv
// step_driver_if: turns step requests into correctly timed STEP/DIR/ENABLE for a stepper driver chip.
// Optional feature: define STEP_ENDSTOP_EN to add the endstop_min input and endstop_hit tracking.
module step_driver_if #(
  parameter int PULSE_HIGH = 5,
  parameter int PULSE_LOW  = 5,
  parameter int DIR_SETUP  = 10,
  parameter int POS_WIDTH  = 32,
  parameter int PEND_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable_in,
  input  logic                        dir_in,
  input  logic                        step_in,
  input  logic                        clear,
`ifdef STEP_ENDSTOP_EN
  input  logic                        endstop_min,
`endif
  output logic                        drv_step,
  output logic                        drv_dir,
  output logic                        drv_enable_n,
  output logic signed [POS_WIDTH-1:0] position,
  output logic                        busy,
  output logic                        overrun,
  output logic                        endstop_hit
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] HIGH  = 2'd2;
  localparam logic [1:0] LOW   = 2'd3;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]      SETUP_LAST = CNT_W'(DIR_SETUP - 1);
  localparam logic [CNT_W-1:0]      HIGH_LAST  = CNT_W'(PULSE_HIGH - 1);
  localparam logic [CNT_W-1:0]      LOW_LAST   = CNT_W'(PULSE_LOW - 1);
  localparam logic [PEND_WIDTH-1:0] PEND_MAX   = '1;
  localparam logic [PEND_WIDTH-1:0] PEND_ONE   = PEND_WIDTH'(1);
  localparam logic [POS_WIDTH-1:0]  POS_ONE    = POS_WIDTH'(1);

  logic [1:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic [PEND_WIDTH-1:0] pending;
  logic                  step_prev;
  logic                  step_edge;
  logic                  start_ok;
  logic                  endstop_block;
  logic                  enter_high;
  logic                  step_drop;

  // enter_high marks the single cycle in which a pulse is committed: it both
  // consumes a pending step and moves the position.
  always_comb begin
    step_edge = step_in & ~step_prev & enable_in;
    start_ok  = (state == IDLE) && enable_in && (pending != '0);
`ifdef STEP_ENDSTOP_EN
    endstop_block = start_ok && !dir_in && endstop_min;
`else
    endstop_block = 1'b0;
`endif
    enter_high = 1'b0;
    if (start_ok && !endstop_block && (dir_in == drv_dir))
      enter_high = 1'b1;
    if ((state == SETUP) && enable_in && (cnt == SETUP_LAST))
      enter_high = 1'b1;
    step_drop = step_edge && !enter_high && !endstop_block && (pending == PEND_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step_prev    <= 1'b0;
      drv_enable_n <= 1'b1;
    end else begin
      step_prev    <= step_in;
      drv_enable_n <= ~enable_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      pending <= '0;
    else if (!enable_in || endstop_block)
      pending <= '0;
    else if (step_edge && !enter_high) begin
      if (pending != PEND_MAX)
        pending <= pending + PEND_ONE;
    end else if (!step_edge && enter_high)
      pending <= pending - PEND_ONE;
  end

  // Pulses already on the wire always run to completion; only SETUP may abort.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      drv_step <= 1'b0;
      drv_dir  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (enter_high) begin
            state    <= HIGH;
            drv_step <= 1'b1;
          end else if (start_ok && !endstop_block) begin
            drv_dir <= dir_in;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (!enable_in) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (enter_high) begin
            state    <= HIGH;
            drv_step <= 1'b1;
            cnt      <= '0;
          end else
            cnt <= cnt + CNT_ONE;
        end
        HIGH: begin
          if (cnt == HIGH_LAST) begin
            state    <= LOW;
            drv_step <= 1'b0;
            cnt      <= '0;
          end else
            cnt <= cnt + CNT_ONE;
        end
        LOW: begin
          if (cnt == LOW_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else
            cnt <= cnt + CNT_ONE;
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          drv_step <= 1'b0;
        end
      endcase
    end
  end

  // clear outranks a same-cycle position update, so that step's +/-1 is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      position <= '0;
      overrun  <= 1'b0;
    end else if (clear) begin
      position <= '0;
      overrun  <= 1'b0;
    end else begin
      if (endstop_block)
        position <= '0;
      else if (enter_high)
        position <= drv_dir ? (position + POS_ONE) : (position - POS_ONE);
      if (step_drop)
        overrun <= 1'b1;
    end
  end

`ifdef STEP_ENDSTOP_EN
  always_ff @(posedge clk) begin
    if (reset || clear)
      endstop_hit <= 1'b0;
    else if (endstop_block)
      endstop_hit <= 1'b1;
  end
`else
  assign endstop_hit = 1'b0;
`endif

  assign busy = (pending != '0) || (state != IDLE);

endmodule
